// File: rtl/gpio_mwr_pkg.sv
// Shared types for the GPIO masked-write scheduler.
// Beat bundle, FSM state encoding and data widths.
package gpio_mwr_pkg;

   localparam int GpioMwrHalfW = 16;
   localparam int GpioMwrDataW = 32;

   typedef struct packed {
      logic                    oe;
      logic                    upper;
      logic [GpioMwrHalfW-1:0] data;
      logic [GpioMwrHalfW-1:0] mask;
   } gpio_mwr_beat_t;

   typedef enum logic [1:0] {
      IDLE,
      LOWER,
      UPPER
   } gpio_mwr_state_e;

endpackage

// File: rtl/gpio_rr_arb.sv
// Combinational round-robin arbiter.
// Search starts at ptr+1 and wraps, so ptr marks the last winner.
import gpio_mwr_pkg::*;

module gpio_rr_arb #(
   parameter int NumReq = 4,
   parameter int IdxW   = $clog2(NumReq)
) (
   input  logic [NumReq-1:0] req,
   input  logic [IdxW-1:0]   ptr,
   output logic [NumReq-1:0] gnt,
   output logic [IdxW-1:0]   idx
);

   logic            found;
   logic [IdxW-1:0] cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 1; i <= NumReq; i++) begin
         cand = IdxW'((int'(ptr) + i) % NumReq);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/gpio_masked_wr_sched.sv
// Splits requester masked writes into 16-bit beats for the GPIO block.
// Define GPIO_MWR_STATS_EN to build the beat/stall statistics counters.
import gpio_mwr_pkg::*;

module gpio_masked_wr_sched #(
   parameter int NumReq = 4,
   parameter int StatW  = 16
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [NumReq-1:0]                    req_i,
   input  logic [NumReq-1:0]                    req_oe_i,
   input  logic [NumReq-1:0][GpioMwrDataW-1:0] req_data_i,
   input  logic [NumReq-1:0][GpioMwrDataW-1:0] req_mask_i,
   output logic [NumReq-1:0]                    gnt_o,
   output logic [NumReq-1:0]                    done_o,
   output logic                                 wr_valid_o,
   input  logic                                 wr_ready_i,
   output gpio_mwr_beat_t                       wr_beat_o,
   output logic                                 busy_o,
   output logic [StatW-1:0]                     stat_beats_o,
   output logic [StatW-1:0]                     stat_stalls_o
);

   localparam int IdxW = $clog2(NumReq);

   gpio_mwr_state_e   state, nxt;
   logic [IdxW-1:0]   ptr;
   logic [NumReq-1:0] arb_gnt;
   logic [IdxW-1:0]   arb_idx;
   logic              lat_oe;
   logic [GpioMwrDataW-1:0] lat_data;
   logic [GpioMwrDataW-1:0] lat_mask;
   logic [IdxW-1:0]   lat_idx;
   logic [GpioMwrDataW-1:0] win_mask;
   logic              take;

   gpio_rr_arb #(
      .NumReq (NumReq),
      .IdxW   (IdxW)
   ) u_arb (
      .req (req_i),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   assign win_mask = req_mask_i[arb_idx];
   assign take     = (state == IDLE) && (|req_i);
   assign busy_o   = (state != IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         ptr      <= IdxW'(NumReq - 1);
         lat_oe   <= 1'b0;
         lat_data <= '0;
         lat_mask <= '0;
         lat_idx  <= '0;
      end else begin
         state <= nxt;
         if (take) begin
            ptr      <= arb_idx;
            lat_oe   <= req_oe_i[arb_idx];
            lat_data <= req_data_i[arb_idx];
            lat_mask <= win_mask;
            lat_idx  <= arb_idx;
         end
      end
   end

   always_comb begin
      nxt        = state;
      gnt_o      = '0;
      done_o     = '0;
      wr_valid_o = 1'b0;
      wr_beat_o  = '0;
      unique case (state)
         IDLE: begin
            if (take && !rst_i) begin
               gnt_o = arb_gnt;
               if (win_mask[GpioMwrHalfW-1:0] != '0) begin
                  nxt = LOWER;
               end else if (win_mask[GpioMwrDataW-1:GpioMwrHalfW] != '0) begin
                  nxt = UPPER;
               end else begin
                  // Nothing to write: retire in the grant cycle.
                  done_o = arb_gnt;
               end
            end
         end
         LOWER: begin
            wr_valid_o      = 1'b1;
            wr_beat_o.oe    = lat_oe;
            wr_beat_o.upper = 1'b0;
            wr_beat_o.data  = lat_data[GpioMwrHalfW-1:0];
            wr_beat_o.mask  = lat_mask[GpioMwrHalfW-1:0];
            if (wr_ready_i) begin
               if (lat_mask[GpioMwrDataW-1:GpioMwrHalfW] != '0) begin
                  nxt = UPPER;
               end else begin
                  nxt             = IDLE;
                  done_o[lat_idx] = 1'b1;
               end
            end
         end
         UPPER: begin
            wr_valid_o      = 1'b1;
            wr_beat_o.oe    = lat_oe;
            wr_beat_o.upper = 1'b1;
            wr_beat_o.data  = lat_data[GpioMwrDataW-1:GpioMwrHalfW];
            wr_beat_o.mask  = lat_mask[GpioMwrDataW-1:GpioMwrHalfW];
            if (wr_ready_i) begin
               nxt             = IDLE;
               done_o[lat_idx] = 1'b1;
            end
         end
         default: nxt = IDLE;
      endcase
   end

`ifdef GPIO_MWR_STATS_EN
   logic [StatW-1:0] beats;
   logic [StatW-1:0] stalls;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         beats  <= '0;
         stalls <= '0;
      end else begin
         if (wr_valid_o && wr_ready_i && (beats != '1)) begin
            beats <= beats + 1'b1;
         end
         if (wr_valid_o && !wr_ready_i && (stalls != '1)) begin
            stalls <= stalls + 1'b1;
         end
      end
   end

   assign stat_beats_o  = beats;
   assign stat_stalls_o = stalls;
`else
   assign stat_beats_o  = '0;
   assign stat_stalls_o = '0;
`endif

endmodule
